jtag_bridge: RTL
================

# jtag_bridge

Parametrised, registered bridge from the FTDI UART handshake lines to an external JTAG port. Sits between the FTDI pin buffers and the JTAG header pins in the top level. It replaces a purely combinational pass-through with:
- input synchronisation and optional glitch filtering;
- an idle/active state machine that releases the JTAG outputs after a TCK-inactivity timeout;
- a TCK edge counter;
- per-line LED activity stretchers.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser flops per input (≥2)
- FILTER_CYCLES, 4, consecutive cycles a new level must persist before acceptance (1..255)
- IDLE_TIMEOUT, 1000000, clk cycles without a TCK edge before returning to IDLE (≥2)
- STRETCH, 2000000, LED on-time in clk cycles after each edge (≥1)
- CNT_WIDTH, 16, width of tck_count

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ftdi_txd  in  1  async; source of TDI
- ftdi_nrts  in  1  async; source of TMS
- ftdi_ndtr  in  1  async; source of TCK
- jtag_tdo  in  1  async; TDO from target
- jtag_tdi  out  1  registered TDI
- jtag_tms  out  1  registered TMS
- jtag_tck  out  1  registered TCK
- jtag_oe  out  1  1 = JTAG outputs valid/driven (ACTIVE)
- ftdi_rxd  out  1  registered TDO to FTDI
- active  out  1  FSM in ACTIVE
- tck_count  out  CNT_WIDTH  rising TCK edges seen
- led  out  4  stretched activity: [0] TDO, [1] TDI, [2] TMS, [3] TCK

## Operation
- Synchroniser: each of the 4 inputs passes through SYNC_STAGES flops. All flops reset to 1.
- Filter, per channel: a counter tracks how long the synced value has differed from the filtered value f_x.
  - The counter increments each cycle the two differ and clears on any cycle they are equal.
  - When the counter reaches FILTER_CYCLES, f_x takes the synced value and the counter clears.
  - f_x resets to 1.
- Edges: each channel's f_x is delayed one cycle. edge_x = f_x ^ f_x_d; tck_rise = f_ndtr & ~f_ndtr_d.
- FSM, states IDLE (reset) and ACTIVE:
  - IDLE→ACTIVE on any edge of f_ndtr.
  - In ACTIVE, a timer clears on every f_ndtr edge and otherwise increments.
  - ACTIVE→IDLE when the timer reaches IDLE_TIMEOUT-1 without an edge. If an edge coincides with expiry, the edge wins and the FSM stays ACTIVE.
- Outputs in ACTIVE: jtag_tdi=f_txd, jtag_tms=f_nrts, jtag_tck=f_ndtr, ftdi_rxd=f_tdo, jtag_oe=1.
- Outputs in IDLE: jtag_tdi=1, jtag_tms=1, jtag_tck=0, ftdi_rxd=1, jtag_oe=0.
- tck_count: increments on tck_rise in either state and wraps modulo 2^CNT_WIDTH. It is cleared only by rst. The rise that triggers IDLE→ACTIVE is counted.
- LED stretcher, per channel: any edge_x reloads a down-counter with STRETCH; the counter decrements to 0 otherwise. led[i] = (counter ≠ 0).
- Reset values: jtag_tdi=1, jtag_tms=1, jtag_tck=0, ftdi_rxd=1, jtag_oe=0, active=0, tck_count=0, led=0, FSM=IDLE, all timers 0.
- Reset mid-operation immediately forces every output to its reset value and abandons any pending filter or timer count.

## Timing
- All outputs are registered. There are no combinational input→output paths.
- Latency, filter compiled in: an input level held stable appears on the corresponding output SYNC_STAGES+FILTER_CYCLES+1 clk edges after first being sampled.
- Latency, filter compiled out: SYNC_STAGES+1 edges.
- The FSM transition takes effect on the same edge as the f_ndtr output update: the first TCK edge appears on jtag_tck together with jtag_oe=1.
- Pulses shorter than FILTER_CYCLES cycles after synchronisation never reach the outputs, counter, FSM or LEDs.
- The TCK frequency must stay below clk/(2·FILTER_CYCLES) for lossless passing.

## Configuration
- JTAG_BRIDGE_FILTER_EN defined: the glitch filters are instantiated as described.
- JTAG_BRIDGE_FILTER_EN undefined: f_x equals the last synchroniser stage, FILTER_CYCLES is ignored, and latency is SYNC_STAGES+1.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then idle inputs for 100 cycles -> jtag_oe=0, jtag_tck=0, jtag_tdi=1, jtag_tms=1, ftdi_rxd=1, tck_count=0, led=0.
- ftdi_ndtr toggled 10 times, each level held 20 cycles (defaults, filter on) -> first jtag_tck change and jtag_oe=1 appear 7 cycles after the first toggle; tck_count=5; led[3]=1.
- 3-cycle low glitch on ftdi_txd in ACTIVE, filter on -> jtag_tdi stays 1, led[1] stays 0. Same stimulus with the filter off -> jtag_tdi pulses low for 3 cycles.
- IDLE_TIMEOUT=50, one TCK edge then no activity -> jtag_oe drops exactly 50 cycles after the edge reaches f_ndtr. A second run with an edge landing on the expiry cycle -> jtag_oe stays 1.
- CNT_WIDTH=4, 17 TCK rising edges -> tck_count=1 (wrap).
- Assert rst during ACTIVE with led[3]=1 -> all outputs return to their reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/jtag_bridge_if.sv
`default_nettype none
// ============================================================
// Module : jtag_bridge_if
// Desc   : FTDI/JTAG pin bundle for jtag_bridge (slave = bridge side).
// Rev    : 1.0
// ============================================================
interface jtag_bridge_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 ftdi_txd;
    logic                 ftdi_nrts;
    logic                 ftdi_ndtr;
    logic                 jtag_tdo;
    logic                 jtag_tdi;
    logic                 jtag_tms;
    logic                 jtag_tck;
    logic                 jtag_oe;
    logic                 ftdi_rxd;
    logic                 active;
    logic [CNT_WIDTH-1:0] tck_count;
    logic [3:0]           led;

    modport slave (
        input  ftdi_txd, ftdi_nrts, ftdi_ndtr, jtag_tdo,
        output jtag_tdi, jtag_tms, jtag_tck, jtag_oe, ftdi_rxd, active, tck_count, led
    );

    modport master (
        output ftdi_txd, ftdi_nrts, ftdi_ndtr, jtag_tdo,
        input  jtag_tdi, jtag_tms, jtag_tck, jtag_oe, ftdi_rxd, active, tck_count, led
    );
endinterface
`default_nettype wire

// File: rtl/jtag_bridge.sv
`default_nettype none
// ============================================================
// Module : jtag_bridge
// Desc   : Registered FTDI-to-JTAG bridge: synchroniser, glitch filter
//          (enabled by JTAG_BRIDGE_FILTER_EN), idle timeout FSM,
//          TCK rise counter and LED activity stretchers.
// Rev    : 1.0
// ============================================================
module jtag_bridge #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int IDLE_TIMEOUT  = 1000000,
    parameter int STRETCH       = 2000000,
    parameter int CNT_WIDTH     = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    jtag_bridge_if.slave bus
);
    localparam int c_TW = $clog2(IDLE_TIMEOUT);
    localparam int c_SW = $clog2(STRETCH + 1);
    localparam logic [c_TW-1:0] c_TIMER_EXP = c_TW'(IDLE_TIMEOUT - 2);
    localparam logic [c_SW-1:0] c_STRETCH   = c_SW'(STRETCH);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || FILTER_CYCLES > 255 ||
        IDLE_TIMEOUT < 2 || STRETCH < 1) begin : g_param_check
        $error("jtag_bridge: parameter out of range");
    end

    // Channel order matches led[]: 0=TDO, 1=TDI, 2=TMS, 3=TCK
    logic [3:0] w_in;
    assign w_in = {bus.ftdi_ndtr, bus.ftdi_nrts, bus.ftdi_txd, bus.jtag_tdo};

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0]                  w_sync;
    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
    end

    logic [3:0] w_filt;
`ifdef JTAG_BRIDGE_FILTER_EN
    localparam logic [7:0] c_FILT_LAST = 8'(FILTER_CYCLES - 1);
    logic [3:0]      r_filt;
    logic [3:0][7:0] r_fcnt;

    // A new level is accepted on the FILTER_CYCLES-th consecutive differing cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= '1;
            r_fcnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == c_FILT_LAST) begin
                    r_filt[i] <= w_sync[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 8'd1;
                end
            end
        end
    end
    assign w_filt = r_filt;
`else
    assign w_filt = w_sync;
`endif

    logic [3:0] r_filt_d;
    logic [3:0] w_edge;
    logic       w_tck_rise;
    assign w_edge     = w_filt ^ r_filt_d;
    assign w_tck_rise = w_filt[3] & ~r_filt_d[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_filt_d <= '1;
        else     r_filt_d <= w_filt;
    end

    state_t          r_state;
    logic [c_TW-1:0] r_timer;
    logic            r_tdi, r_tms, r_tck, r_rxd, r_oe;
    logic            w_expire;
    logic            w_next_active;

    // A TCK edge on the expiry cycle keeps the bridge ACTIVE
    assign w_expire      = (r_state == S_ACTIVE) && !w_edge[3] && (r_timer == c_TIMER_EXP);
    assign w_next_active = (r_state == S_ACTIVE) ? !w_expire : w_edge[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_tdi   <= 1'b1;
            r_tms   <= 1'b1;
            r_tck   <= 1'b0;
            r_rxd   <= 1'b1;
            r_oe    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_edge[3]) r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (w_edge[3]) begin
                        r_timer <= '0;
                    end else if (w_expire) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                end
            endcase
            // Outputs follow the next state so the first TCK edge and OE appear together
            r_tdi <= w_next_active ? w_filt[1] : 1'b1;
            r_tms <= w_next_active ? w_filt[2] : 1'b1;
            r_tck <= w_next_active ? w_filt[3] : 1'b0;
            r_rxd <= w_next_active ? w_filt[0] : 1'b1;
            r_oe  <= w_next_active;
        end
    end

    logic [CNT_WIDTH-1:0] r_tck_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_tck_cnt <= '0;
        else if (w_tck_rise) r_tck_cnt <= r_tck_cnt + 1'b1;
    end

    logic [3:0][c_SW-1:0] r_str;
    logic [3:0]           r_led;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_str <= '0;
            r_led <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_edge[i])         r_str[i] <= c_STRETCH;
                else if (r_str[i] != 0) r_str[i] <= r_str[i] - 1'b1;
                r_led[i] <= w_edge[i] || (r_str[i] > c_SW'(1));
            end
        end
    end

    assign bus.jtag_tdi  = r_tdi;
    assign bus.jtag_tms  = r_tms;
    assign bus.jtag_tck  = r_tck;
    assign bus.ftdi_rxd  = r_rxd;
    assign bus.jtag_oe   = r_oe;
    assign bus.active    = r_oe;
    assign bus.tck_count = r_tck_cnt;
    assign bus.led       = r_led;
endmodule
`default_nettype wire
